// File: rtl/pool_win_ctrl.sv
// pool_win_ctrl: window sequencer and result collector for the max-pooling PE.
//
// Counts incoming feature-element beats into windows of win elements, drives
// the max unit's clear/enable so every window is reduced independently, and
// captures the max unit's combinational result on the last element of each
// window into a 2-entry FIFO toward writeback.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_start               job start pulse (sampled in IDLE only)
//   i_cfg_win_size        elements per window (0 treated as 1)
//   i_cfg_num_win         windows per job (0 completes immediately)
//   i_up_vld / o_up_rdy   upstream element handshake
//   o_mdata_vld           element valid toward the max unit
//   o_max_clear/o_max_en  max unit accumulator control
//   i_max_result          max unit output (low DATA_COPIES*DATA_WIDTH bits used)
//   o_pool_data/o_pool_vld/i_pool_rdy  result FIFO head and handshake
//   o_busy                job in progress
//   o_done                one-cycle pulse at job end
module pool_win_ctrl #(
   parameter int DATA_WIDTH  = 8,
   parameter int DATA_COPIES = 32,
   parameter int WIN_CNT_W   = 5,
   parameter int NWIN_W      = 16
) (
   input  logic                                 i_clk,
   input  logic                                 i_rst_n,
   input  logic                                 i_start,
   input  logic [WIN_CNT_W-1:0]                 i_cfg_win_size,
   input  logic [NWIN_W-1:0]                    i_cfg_num_win,
   input  logic                                 i_up_vld,
   output logic                                 o_up_rdy,
   output logic                                 o_mdata_vld,
   output logic                                 o_max_clear,
   output logic                                 o_max_en,
   input  logic [DATA_COPIES*2*DATA_WIDTH-1:0]  i_max_result,
   output logic [DATA_COPIES*DATA_WIDTH-1:0]    o_pool_data,
   output logic                                 o_pool_vld,
   input  logic                                 i_pool_rdy,
   output logic                                 o_busy,
   output logic                                 o_done
);

   localparam int LW = DATA_COPIES * DATA_WIDTH;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                 state_q, state_d;
   logic [WIN_CNT_W-1:0]   elem_cnt_q, elem_cnt_d;
   logic [WIN_CNT_W-1:0]   win_q, win_d;
   logic [NWIN_W-1:0]      win_cnt_q, win_cnt_d;
   logic [NWIN_W-1:0]      nwin_q, nwin_d;
   logic [1:0][LW-1:0]     fifo_q;
   logic [1:0]             fifo_cnt_q;
   logic                   done_q, done_d;
   logic                   push, pop, last, accept;
   logic                   unused_hi;

   // The max unit produces double-width lanes; only the low half is pooled.
   assign unused_hi = ^i_max_result[2*LW-1:LW];

   assign pop         = o_pool_vld & i_pool_rdy;
   assign o_pool_vld  = (fifo_cnt_q != 2'd0);
   assign o_pool_data = fifo_q[0];
   assign o_busy      = (state_q != IDLE);
   assign o_done      = done_q;
   assign o_mdata_vld = accept;

   always_comb begin
      state_d     = state_q;
      elem_cnt_d  = elem_cnt_q;
      win_cnt_d   = win_cnt_q;
      win_d       = win_q;
      nwin_d      = nwin_q;
      o_up_rdy    = 1'b0;
      o_max_en    = 1'b0;
      o_max_clear = 1'b1;
      push        = 1'b0;
      done_d      = 1'b0;
      accept      = 1'b0;
      last        = (elem_cnt_q == win_q - WIN_CNT_W'(1));
      case (state_q)
         IDLE: begin
            if (i_start) begin
               win_d      = (i_cfg_win_size == '0) ? WIN_CNT_W'(1) : i_cfg_win_size;
               nwin_d     = i_cfg_num_win;
               elem_cnt_d = '0;
               win_cnt_d  = '0;
               state_d    = (i_cfg_num_win == '0) ? DRAIN : RUN;
            end
         end
         RUN: begin
            o_max_en    = 1'b1;
            o_max_clear = 1'b0;
            // Only the window-closing element needs a FIFO slot; no credit is
            // taken for a pop in the same cycle to keep o_up_rdy off i_pool_rdy.
            o_up_rdy    = !last | (fifo_cnt_q != 2'd2);
            accept      = i_up_vld & o_up_rdy;
            if (accept) begin
               if (last) begin
                  elem_cnt_d  = '0;
                  push        = 1'b1;
                  // Result already contains this element (combinational max),
                  // so the accumulator can restart for the next window now.
                  o_max_clear = 1'b1;
                  win_cnt_d   = win_cnt_q + NWIN_W'(1);
                  if (win_cnt_q == nwin_q - NWIN_W'(1)) state_d = DRAIN;
               end else begin
                  elem_cnt_d = elem_cnt_q + WIN_CNT_W'(1);
               end
            end
         end
         DRAIN: begin
            if (fifo_cnt_q == 2'd0 || (fifo_cnt_q == 2'd1 && pop)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         elem_cnt_q <= '0;
         win_cnt_q  <= '0;
         win_q      <= WIN_CNT_W'(1);
         nwin_q     <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         elem_cnt_q <= elem_cnt_d;
         win_cnt_q  <= win_cnt_d;
         win_q      <= win_d;
         nwin_q     <= nwin_d;
         done_q     <= done_d;
      end
   end

   // Two-entry FIFO with entry 0 always the registered head.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         fifo_q     <= '0;
         fifo_cnt_q <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (fifo_cnt_q == 2'd0) fifo_q[0] <= i_max_result[LW-1:0];
               else                    fifo_q[1] <= i_max_result[LW-1:0];
               fifo_cnt_q <= fifo_cnt_q + 2'd1;
            end
            2'b01: begin
               fifo_q[0]  <= fifo_q[1];
               fifo_cnt_q <= fifo_cnt_q - 2'd1;
            end
            2'b11: begin
               if (fifo_cnt_q == 2'd1) begin
                  fifo_q[0] <= i_max_result[LW-1:0];
               end else begin
                  fifo_q[0] <= fifo_q[1];
                  fifo_q[1] <= i_max_result[LW-1:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule
